// File: rtl/rect_plotter.sv
// rtl/rect_plotter.sv - rectangle pixel walker driving the frame-buffer plot strobe (optional RECT_CLIP_EN screen clipping)
module rect_plotter #(
    parameter int X_WIDTH      = 8,
    parameter int Y_WIDTH      = 7,
    parameter int COLOUR_WIDTH = 3,
    parameter int SCREEN_W     = 160,
    parameter int SCREEN_H     = 120
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic [X_WIDTH-1:0]      x0,
    input  logic [Y_WIDTH-1:0]      y0,
    input  logic [3:0]              w_m1,
    input  logic [3:0]              h_m1,
    input  logic [COLOUR_WIDTH-1:0] colour_in,
    output logic [X_WIDTH-1:0]      x,
    output logic [Y_WIDTH-1:0]      y,
    output logic [COLOUR_WIDTH-1:0] colour,
    output logic                    plot,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;

    // request fields captured on acceptance so the caller may change inputs freely
    logic [X_WIDTH-1:0]      x0_q, x0_d;
    logic [Y_WIDTH-1:0]      y0_q, y0_d;
    logic [3:0]              w_q, w_d;
    logic [3:0]              h_q, h_d;
    logic [COLOUR_WIDTH-1:0] col_q, col_d;

    // offset of the pixel currently presented on x/y
    logic [3:0]              dx_q, dx_d;
    logic [3:0]              dy_q, dy_d;

    logic [X_WIDTH-1:0]      x_q, x_d;
    logic [Y_WIDTH-1:0]      y_q, y_d;
    logic [COLOUR_WIDTH-1:0] colour_q, colour_d;
    logic                    plot_q, plot_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    // the next cycle presents a pixel (before any screen mask)
    logic                    draw_d;

`ifdef RECT_CLIP_EN
    localparam logic [X_WIDTH:0] SCREEN_W_L = (X_WIDTH+1)'(SCREEN_W);
    localparam logic [Y_WIDTH:0] SCREEN_H_L = (Y_WIDTH+1)'(SCREEN_H);

    // one extra bit keeps the coordinate unwrapped so off-screen pixels are detectable
    logic [X_WIDTH:0]        ux_d;
    logic [Y_WIDTH:0]        uy_d;
`endif

    // state register and all registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            col_q    <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            w_q      <= w_d;
            h_q      <= h_d;
            col_q    <= col_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // next-state, row-major walk and next output values
    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        w_d      = w_q;
        h_d      = h_q;
        col_d    = col_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        draw_d   = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        plot_d   = 1'b0;
`ifdef RECT_CLIP_EN
        ux_d     = '0;
        uy_d     = '0;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRAW;
                    x0_d    = x0;
                    y0_d    = y0;
                    w_d     = w_m1;
                    h_d     = h_m1;
                    col_d   = colour_in;
                    dx_d    = '0;
                    dy_d    = '0;
                    draw_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            DRAW: begin
                busy_d = 1'b1;
                if (dx_q == w_q) begin
                    dx_d = '0;
                    if (dy_q == h_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        dy_d   = dy_q + 4'd1;
                        draw_d = 1'b1;
                    end
                end else begin
                    dx_d   = dx_q + 4'd1;
                    draw_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // coordinates only update while drawing; otherwise they hold the last pixel
        if (draw_d) begin
            colour_d = col_d;
`ifdef RECT_CLIP_EN
            ux_d   = {1'b0, x0_d} + {{(X_WIDTH-3){1'b0}}, dx_d};
            uy_d   = {1'b0, y0_d} + {{(Y_WIDTH-3){1'b0}}, dy_d};
            x_d    = ux_d[X_WIDTH-1:0];
            y_d    = uy_d[Y_WIDTH-1:0];
            plot_d = (ux_d < SCREEN_W_L) && (uy_d < SCREEN_H_L);
`else
            x_d    = x0_d + {{(X_WIDTH-4){1'b0}}, dx_d};
            y_d    = y0_d + {{(Y_WIDTH-4){1'b0}}, dy_d};
            plot_d = 1'b1;
`endif
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_rect_plotter.sv
// tb/tb_rect_plotter.sv - scoreboard bench for rect_plotter
module tb_rect_plotter;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [3:0] w_m1;
    logic [3:0] h_m1;
    logic [2:0] colour_in;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [17:0] sb[$];
    logic [17:0] exp_px;

    rect_plotter dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .x0        (x0),
        .y0        (y0),
        .w_m1      (w_m1),
        .h_m1      (h_m1),
        .colour_in (colour_in),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic bit on_screen(int ux, int uy);
`ifdef RECT_CLIP_EN
        return (ux < 160) && (uy < 120);
`else
        return 1'b1;
`endif
    endfunction

    function automatic void push_rect(int px, int py, int w, int h, int c);
        logic [31:0] ux;
        logic [31:0] uy;
        logic [31:0] cc;
        for (int j = 0; j <= h; j++) begin
            for (int i = 0; i <= w; i++) begin
                ux = 32'(px + i);
                uy = 32'(py + j);
                cc = 32'(c);
                if (on_screen(px + i, py + j))
                    sb.push_back({ux[7:0], uy[6:0], cc[2:0]});
            end
        end
    endfunction

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0;
        x0 = '0; y0 = '0; w_m1 = '0; h_m1 = '0; colour_in = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({x, y, colour, plot, busy, done} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got x=%0d y=%0d c=%0d p=%b b=%b d=%b want all 0", x, y, colour, plot, busy, done);
        end
        resetn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_tests++;
            if ({plot, busy, done, x, y} !== 18'd0) begin
                n_fail++;
                $display("FAIL idle_after_reset cyc %0d got p=%b b=%b d=%b x=%0d y=%0d want 0", k, plot, busy, done, x, y);
            end
        end
    endtask

    task automatic test_fill_4x4();
        @(negedge clk);
        x0 = 8'd10; y0 = 7'd20; w_m1 = 4'd3; h_m1 = 4'd3; colour_in = 3'b101; start = 1'b1;
        push_rect(10, 20, 3, 3, 5);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            n_tests++;
            if ({plot, done, busy} !== {k <= 16, k == 17, k <= 17}) begin
                n_fail++;
                $display("FAIL fill4_timing k=%0d got p=%b d=%b b=%b want %b %b %b", k, plot, done, busy, k <= 16, k == 17, k <= 17);
            end
            if (plot) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL fill4_extra_plot got (%0d,%0d) want none", x, y);
                end else begin
                    exp_px = sb.pop_front();
                    if ({x, y, colour} !== exp_px) begin
                        n_fail++;
                        $display("FAIL fill4_pixel got (%0d,%0d,%0d) want (%0d,%0d,%0d)", x, y, colour, exp_px[17:10], exp_px[9:3], exp_px[2:0]);
                    end
                end
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL fill4_missing got %0d pixels left want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        x0 = 8'd0; y0 = 7'd0; w_m1 = 4'd0; h_m1 = 4'd0; colour_in = 3'd2; start = 1'b1;
        push_rect(0, 0, 0, 0, 2);
        push_rect(0, 0, 0, 0, 2);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 4) start = 1'b0;
            n_tests++;
            if ({plot, done, busy} !== {k == 1 || k == 4, k == 2 || k == 5, k == 1 || k == 2 || k == 4 || k == 5}) begin
                n_fail++;
                $display("FAIL b2b_timing k=%0d got p=%b d=%b b=%b", k, plot, done, busy);
            end
            if (plot) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra_plot got (%0d,%0d) want none", x, y);
                end else begin
                    exp_px = sb.pop_front();
                    if ({x, y, colour} !== exp_px) begin
                        n_fail++;
                        $display("FAIL b2b_pixel got (%0d,%0d,%0d) want (%0d,%0d,%0d)", x, y, colour, exp_px[17:10], exp_px[9:3], exp_px[2:0]);
                    end
                end
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_missing got %0d pixels left want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        x0 = 8'd50; y0 = 7'd50; w_m1 = 4'd15; h_m1 = 4'd15; colour_in = 3'd1; start = 1'b1;
        push_rect(50, 50, 15, 15, 1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            n_tests++;
            if (plot !== 1'b1) begin
                n_fail++;
                $display("FAIL midrst_plot k=%0d got %b want 1", k, plot);
            end else if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL midrst_extra_plot got (%0d,%0d) want none", x, y);
            end else begin
                exp_px = sb.pop_front();
                if ({x, y, colour} !== exp_px) begin
                    n_fail++;
                    $display("FAIL midrst_pixel got (%0d,%0d,%0d) want (%0d,%0d,%0d)", x, y, colour, exp_px[17:10], exp_px[9:3], exp_px[2:0]);
                end
            end
        end
        #2 resetn = 1'b0;
        #1;
        n_tests++;
        if ({plot, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_async got p=%b b=%b d=%b want 000", plot, busy, done);
        end
        n_tests++;
        if (sb.size() != 249) begin
            n_fail++;
            $display("FAIL midrst_count got %0d pending want 249", sb.size());
        end
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_tests++;
            if ({plot, busy, done} !== 3'b000) begin
                n_fail++;
                $display("FAIL midrst_idle cyc %0d got p=%b b=%b d=%b want 000", k, plot, busy, done);
            end
        end
    endtask

    task automatic test_edge_wrap();
        int nplot = 0;
        int want_plots = 0;
        bit exp_plot;
        @(negedge clk);
        x0 = 8'd155; y0 = 7'd118; w_m1 = 4'd7; h_m1 = 4'd3; colour_in = 3'd6; start = 1'b1;
        push_rect(155, 118, 7, 3, 6);
        want_plots = sb.size();
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            exp_plot = (k <= 32) && on_screen(155 + (k - 1) % 8, 118 + (k - 1) / 8);
            n_tests++;
            if ({plot, done, busy} !== {exp_plot, k == 33, k <= 33}) begin
                n_fail++;
                $display("FAIL edge_timing k=%0d got p=%b d=%b b=%b want %b %b %b", k, plot, done, busy, exp_plot, k == 33, k <= 33);
            end
            if (plot) begin
                nplot++;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL edge_extra_plot got (%0d,%0d) want none", x, y);
                end else begin
                    exp_px = sb.pop_front();
                    if ({x, y, colour} !== exp_px) begin
                        n_fail++;
                        $display("FAIL edge_pixel got (%0d,%0d,%0d) want (%0d,%0d,%0d)", x, y, colour, exp_px[17:10], exp_px[9:3], exp_px[2:0]);
                    end
                end
            end
        end
        n_tests++;
`ifdef RECT_CLIP_EN
        if (nplot != 10 || want_plots != 10) begin
`else
        if (nplot != 32 || want_plots != 32) begin
`endif
            n_fail++;
            $display("FAIL edge_plot_count got %0d want %0d", nplot, want_plots);
        end
        sb.delete();
    endtask

    task automatic test_input_change();
        @(negedge clk);
        x0 = 8'd5; y0 = 7'd5; w_m1 = 4'd1; h_m1 = 4'd1; colour_in = 3'd4; start = 1'b1;
        push_rect(5, 5, 1, 1, 4);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 2) begin
                x0 = 8'd99; y0 = 7'd77; colour_in = 3'd1; w_m1 = 4'd9; start = 1'b1;
            end
            if (k == 4) start = 1'b0;
            n_tests++;
            if ({plot, done} !== {k <= 4, k == 5}) begin
                n_fail++;
                $display("FAIL chg_timing k=%0d got p=%b d=%b want %b %b", k, plot, done, k <= 4, k == 5);
            end
            if (plot) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL chg_extra_plot got (%0d,%0d) want none", x, y);
                end else begin
                    exp_px = sb.pop_front();
                    if ({x, y, colour} !== exp_px) begin
                        n_fail++;
                        $display("FAIL chg_pixel got (%0d,%0d,%0d) want (%0d,%0d,%0d)", x, y, colour, exp_px[17:10], exp_px[9:3], exp_px[2:0]);
                    end
                end
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL chg_missing got %0d pixels left want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_fill_4x4();
        test_back_to_back();
        test_mid_reset();
        test_edge_wrap();
        test_input_change();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rect_plotter.md
Name: rect_plotter

Overview:
- Pixel-walk stage that sits directly upstream of the VGA adapter.
- Takes a rectangle request (origin, size, colour) and emits one pixel per clock in row-major order, with a plot strobe (writeEn) for the frame buffer.
- Replaces FSM-driven writeEn, so plot is asserted exactly once per pixel and never loops.
- Up to 16x16 pixels per request; runtime size.

Parameters:
- X_WIDTH, 8, width of x coordinate bus
- Y_WIDTH, 7, width of y coordinate bus
- COLOUR_WIDTH, 3, width of colour bus
- SCREEN_W, 160, visible columns (used only with RECT_CLIP_EN)
- SCREEN_H, 120, visible rows (used only with RECT_CLIP_EN)

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  request strobe; sampled only in IDLE
- x0  in  X_WIDTH  top-left x
- y0  in  Y_WIDTH  top-left y
- w_m1  in  4  width minus one (0 gives 1 px, 15 gives 16 px)
- h_m1  in  4  height minus one
- colour_in  in  COLOUR_WIDTH  fill colour
- x  out  X_WIDTH  pixel x
- y  out  Y_WIDTH  pixel y
- colour  out  COLOUR_WIDTH  pixel colour
- plot  out  1  writeEn to frame buffer
- busy  out  1  request in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: async on resetn low. State goes to IDLE. x, y, colour, plot, busy and done all go to 0, along with the internal dx/dy counters. This holds mid-operation too: the rectangle is abandoned and no done is issued.
- All outputs are registered.
- FSM states: IDLE, DRAW, DONE.
- IDLE: if start=1 at edge T, latch x0, y0, w_m1, h_m1 and colour_in, clear dx/dy, then go to DRAW. Otherwise stay in IDLE.
- DRAW:
  - Each cycle drives x=x0+dx and y=y0+dy with plot=1.
  - First plot is in cycle T+1.
  - dx increments each cycle. When dx==w_m1, dx wraps to 0 and dy increments.
  - When dx==w_m1 and dy==h_m1, go to DONE.
  - Exactly (w_m1+1)*(h_m1+1) plot cycles, contiguous, with no gaps.
- DONE: one cycle with done=1, plot=0, then IDLE. A new start may be accepted in the cycle after DONE.
- busy=1 in every DRAW and DONE cycle, 0 in IDLE.
- start, and input changes, while busy are ignored. Inputs are latched, so they may change freely after acceptance.
- Arithmetic: dx/dy are zero-extended to X_WIDTH/Y_WIDTH and added. Carry out is discarded (wrap modulo 2^X_WIDTH / 2^Y_WIDTH).
- colour holds the latched value for all plot cycles.
- x/y/colour hold their last value outside DRAW. They are only meaningful while plot=1.
- Minimum request (w_m1=h_m1=0): one plot cycle at T+1, done at T+2.

Optional Feature:
- Macro: RECT_CLIP_EN.
- Defined:
  - Each pixel's unwrapped coordinate is computed with one extra bit.
  - plot is forced to 0 for any pixel with x>=SCREEN_W or y>=SCREEN_H.
  - The walk, cycle count, busy and done timing are unchanged; only plot is masked.
- Not defined: plot=1 for every DRAW cycle, and coordinates wrap as above.

Test Plan:
- Reset then idle: resetn=0 then 1, start=0 for 20 cycles -> plot, busy and done stay 0; x=0, y=0.
- 4x4 fill: x0=10, y0=20, w_m1=3, h_m1=3, colour_in=3'b101, start pulse at T -> plot high T+1..T+16 with (10,20),(11,20)..(13,20),(10,21)..(13,23); colour=5 throughout; done=1 at T+17 only; busy high T+1..T+17.
- Single pixel plus back-to-back: w_m1=h_m1=0 at (0,0), then start held high continuously -> plot at T+1, done at T+2, second rectangle's first plot at T+4; start during busy is not re-accepted.
- Mid-operation reset: 16x16 at (50,50), assert resetn=0 at the 7th plot cycle -> plot, busy and done drop to 0 immediately; after release, state is IDLE and no done is seen.
- Edge wrap/clip: x0=155, y0=118, w_m1=7, h_m1=3 -> 32 DRAW cycles, done at T+33.
  - Without RECT_CLIP_EN: 32 plots, all x in 155..162.
  - With RECT_CLIP_EN: plot only for x in 155..159 and y in 118..119, 10 plots total.
- Input change during busy: start a 2x2 at (5,5), change x0 to 99 and colour_in at T+2 -> all four pixels still use (5..6,5..6) and the original colour.
